// File: rtl/layer_addr_pipe.sv
// Layer-address front end: latches a layer header and pixel, computes layer-relative
// coordinates and read enables, and for in-bounds text layers divides layerX by glyph width.
module layer_addr_pipe #(
    parameter int unsigned PIX_W = 11,
    parameter int unsigned DIM_W = 16,
    parameter int unsigned HDR_W = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [HDR_W-1:0] hdr,
    input  logic [PIX_W-1:0] pixelX,
    input  logic [PIX_W-1:0] pixelY,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             readRamEn,
    output logic             readFlashEn,
    output logic [7:0]       layerID,
    output logic [DIM_W-1:0] layerX,
    output logic [DIM_W-1:0] layerY,
    output logic [DIM_W-1:0] charIndex,
    output logic [DIM_W-1:0] charCol,
    output logic [DIM_W-1:0] fontIdx,
    output logic [7:0]       frameIdx
);

    localparam int unsigned CNT_W = $clog2(DIM_W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DIV,
        S_HOLD
    } state_t;

    state_t r_state, w_state_nxt;

    // Latched transaction
    logic             r_pop, r_sprite;
    logic [7:0]       r_id, r_frame;
    logic [DIM_W-1:0] r_width, r_height, r_posX, r_posY, r_font, r_numChars;
    logic [PIX_W-1:0] r_px, r_py;

    // Registered results
    logic             r_ram, r_flash;
    logic [7:0]       r_layerID, r_frameIdx;
    logic [DIM_W-1:0] r_layerX, r_layerY, r_charIndex, r_charCol, r_fontIdx;

    // Divider state
    logic [DIM_W-1:0] r_quo, r_rem;
    logic [CNT_W-1:0] r_cnt;

    logic               w_unused_hdr;
    logic [DIM_W-1:0]   w_layerX, w_layerY;
    logic [2*DIM_W-1:0] w_extent;
    logic               w_in_w, w_in_h, w_in_text;
    logic               w_ram, w_flash, w_go_div;
    logic [DIM_W:0]     w_shift, w_trial;
    logic [DIM_W-1:0]   w_quo_nxt, w_rem_nxt;
    logic               w_div_last;

    // Only the documented header fields are consumed; the rest is intentionally dropped.
    assign w_unused_hdr = ^hdr;

    assign w_layerX  = DIM_W'(r_px) - r_posX;
    assign w_layerY  = DIM_W'(r_py) - r_posY;
    assign w_in_w    = w_layerX < r_width;
    assign w_in_h    = w_layerY < r_height;
    assign w_extent  = {{DIM_W{1'b0}}, r_numChars} * {{DIM_W{1'b0}}, r_width};
    assign w_in_text = {{DIM_W{1'b0}}, w_layerX} < w_extent;
    assign w_ram     = r_pop & w_in_h & (r_sprite ? w_in_w : w_in_text);
    assign w_flash   = r_pop & ~r_sprite & w_in_text & w_in_h;
    assign w_go_div  = w_flash & (r_width != '0);

    // Restoring step: shift in the next dividend bit, subtract if it fits.
    assign w_shift    = {r_rem, r_quo[DIM_W-1]};
    assign w_trial    = w_shift - {1'b0, r_width};
    assign w_rem_nxt  = w_trial[DIM_W] ? w_shift[DIM_W-1:0] : w_trial[DIM_W-1:0];
    assign w_quo_nxt  = {r_quo[DIM_W-2:0], ~w_trial[DIM_W]};
    assign w_div_last = (r_cnt == CNT_W'(DIM_W - 1));

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = S_CALC;
            end
            S_CALC: w_state_nxt = w_go_div ? S_DIV : S_HOLD;
            S_DIV:  if (w_div_last) w_state_nxt = S_HOLD;
            S_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pop       <= 1'b0;
            r_sprite    <= 1'b0;
            r_id        <= '0;
            r_frame     <= '0;
            r_width     <= '0;
            r_height    <= '0;
            r_posX      <= '0;
            r_posY      <= '0;
            r_font      <= '0;
            r_numChars  <= '0;
            r_px        <= '0;
            r_py        <= '0;
            r_ram       <= 1'b0;
            r_flash     <= 1'b0;
            r_layerID   <= '0;
            r_frameIdx  <= '0;
            r_layerX    <= '0;
            r_layerY    <= '0;
            r_charIndex <= '0;
            r_charCol   <= '0;
            r_fontIdx   <= '0;
            r_quo       <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_pop      <= hdr[0];
                        r_sprite   <= hdr[1];
                        r_id       <= hdr[15:8];
                        r_width    <= DIM_W'(hdr[31:16]);
                        r_height   <= DIM_W'(hdr[47:32]);
                        r_posX     <= DIM_W'(hdr[63:48]);
                        r_posY     <= DIM_W'(hdr[79:64]);
                        r_font     <= DIM_W'(hdr[95:80]);
                        r_numChars <= DIM_W'(hdr[111:96]);
                        r_frame    <= hdr[127:120];
                        r_px       <= pixelX;
                        r_py       <= pixelY;
                    end
                end
                S_CALC: begin
                    r_ram       <= w_ram;
                    r_flash     <= w_flash;
                    r_layerID   <= r_id;
                    r_frameIdx  <= r_frame;
                    r_fontIdx   <= r_font;
                    r_layerX    <= w_layerX;
                    r_layerY    <= w_layerY;
                    r_charIndex <= '0;
                    r_charCol   <= w_layerX;
                    r_quo       <= w_layerX;
                    r_rem       <= '0;
                    r_cnt       <= '0;
                end
                S_DIV: begin
                    r_quo <= w_quo_nxt;
                    r_rem <= w_rem_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_div_last) begin
                        r_charIndex <= w_quo_nxt;
                        r_charCol   <= w_rem_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign readRamEn   = r_ram;
    assign readFlashEn = r_flash;
    assign layerID     = r_layerID;
    assign layerX      = r_layerX;
    assign layerY      = r_layerY;
    assign charIndex   = r_charIndex;
    assign charCol     = r_charCol;
    assign fontIdx     = r_fontIdx;
    assign frameIdx    = r_frameIdx;

endmodule

// File: tb/tb_layer_addr_pipe.sv
// Directed self-checking bench for layer_addr_pipe with hand-computed expectations.
module tb_layer_addr_pipe;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] hdr;
    logic [10:0]  pixelX, pixelY;
    logic         out_valid;
    logic         out_ready;
    logic         readRamEn, readFlashEn;
    logic [7:0]   layerID, frameIdx;
    logic [15:0]  layerX, layerY, charIndex, charCol, fontIdx;

    int n_checks = 0;
    int n_errors = 0;
    int lat;
    int seen;
    logic [15:0] held_x;

    layer_addr_pipe #(.PIX_W(11), .DIM_W(16), .HDR_W(128)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .hdr(hdr), .pixelX(pixelX), .pixelY(pixelY), .out_valid(out_valid),
        .out_ready(out_ready), .readRamEn(readRamEn), .readFlashEn(readFlashEn),
        .layerID(layerID), .layerX(layerX), .layerY(layerY), .charIndex(charIndex),
        .charCol(charCol), .fontIdx(fontIdx), .frameIdx(frameIdx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] mk(input logic [1:0] typ, input logic [15:0] w, h,
                                        px, py, nc);
        logic [127:0] r;
        r           = '0;
        r[1:0]      = typ;
        r[7:2]      = 6'h2A;          // don't-care bits
        r[15:8]     = 8'h5A;
        r[31:16]    = w;
        r[47:32]    = h;
        r[63:48]    = px;
        r[79:64]    = py;
        r[95:80]    = 16'h0123;
        r[111:96]   = nc;
        r[119:112]  = 8'hC3;          // don't-care bits
        r[127:120]  = 8'h77;
        return r;
    endfunction

    // Present one transaction; returns just after the accepting edge N.
    task automatic send(input logic [127:0] h, input logic [10:0] x, input logic [10:0] y);
        @(negedge clk);
        hdr = h; pixelX = x; pixelY = y; in_valid = 1'b1;
        chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // lat = number of edges after N until out_valid is seen high (1 => usable at edge N+2).
    task automatic wait_valid(output int l);
        l = 0;
        while (out_valid !== 1'b1 && l < 100) begin
            @(posedge clk); #1;
            l++;
        end
    endtask

    task automatic expect_res(input string tag, input logic ram, input logic fl,
                              input logic [15:0] lx, input logic [15:0] ly,
                              input logic [15:0] ci, input logic [15:0] cc);
        chk({tag, "_readRamEn"},   {31'd0, readRamEn},   {31'd0, ram});
        chk({tag, "_readFlashEn"}, {31'd0, readFlashEn}, {31'd0, fl});
        chk({tag, "_layerX"},      {16'd0, layerX},      {16'd0, lx});
        chk({tag, "_layerY"},      {16'd0, layerY},      {16'd0, ly});
        chk({tag, "_charIndex"},   {16'd0, charIndex},   {16'd0, ci});
        chk({tag, "_charCol"},     {16'd0, charCol},     {16'd0, cc});
        chk({tag, "_layerID"},     {24'd0, layerID},     32'h5A);
        chk({tag, "_fontIdx"},     {16'd0, fontIdx},     32'h0123);
        chk({tag, "_frameIdx"},    {24'd0, frameIdx},    32'h77);
    endtask

    task automatic release_out(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_idle_in_ready"},  {31'd0, in_ready},  32'd1);
        chk({tag, "_idle_out_valid"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        hdr = '0; pixelX = '0; pixelY = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_readRamEn", {31'd0, readRamEn}, 32'd0);
        chk("rst_layerX",    {16'd0, layerX},    32'd0);
        chk("rst_layerID",   {24'd0, layerID},   32'd0);
        chk("rst_frameIdx",  {24'd0, frameIdx},  32'd0);
        @(negedge clk); rst_n = 1'b1;

        // 1. Sprite in bounds
        send(mk(2'b11, 16'd16, 16'd8, 16'd100, 16'd50, 16'd0), 11'd110, 11'd55);
        chk("t1_calc_in_ready",  {31'd0, in_ready},  32'd0);
        chk("t1_calc_out_valid", {31'd0, out_valid}, 32'd0);
        wait_valid(lat);
        chk("t1_latency", lat, 32'd1);
        expect_res("t1", 1'b1, 1'b0, 16'd10, 16'd5, 16'd0, 16'd10);
        release_out("t1");

        // 2. Text in bounds: 37 / 8 = 4 rem 5
        send(mk(2'b01, 16'd8, 16'd12, 16'd0, 16'd0, 16'd5), 11'd37, 11'd3);
        wait_valid(lat);
        chk("t2_latency", lat, 32'd17);
        expect_res("t2", 1'b1, 1'b1, 16'd37, 16'd3, 16'd4, 16'd5);
        release_out("t2");

        // 3. Pixel left of sprite wraps
        send(mk(2'b11, 16'd16, 16'd8, 16'd100, 16'd0, 16'd0), 11'd99, 11'd0);
        wait_valid(lat);
        chk("t3_latency", lat, 32'd1);
        expect_res("t3", 1'b0, 1'b0, 16'hFFFF, 16'd0, 16'd0, 16'hFFFF);
        release_out("t3");

        // 4a. Text X == numChars*width: out of bounds, no divide
        send(mk(2'b01, 16'd8, 16'd12, 16'd0, 16'd0, 16'd5), 11'd40, 11'd0);
        wait_valid(lat);
        chk("t4a_latency", lat, 32'd1);
        expect_res("t4a", 1'b0, 1'b0, 16'd40, 16'd0, 16'd0, 16'd40);
        release_out("t4a");

        // 4b. Last in-bounds column: 39 / 8 = 4 rem 7
        send(mk(2'b01, 16'd8, 16'd12, 16'd0, 16'd0, 16'd5), 11'd39, 11'd0);
        wait_valid(lat);
        chk("t4b_latency", lat, 32'd17);
        expect_res("t4b", 1'b1, 1'b1, 16'd39, 16'd0, 16'd4, 16'd7);
        release_out("t4b");

        // Text with width 0: enables off, no divide
        send(mk(2'b01, 16'd0, 16'd12, 16'd0, 16'd0, 16'd5), 11'd3, 11'd1);
        wait_valid(lat);
        chk("w0_latency", lat, 32'd1);
        expect_res("w0", 1'b0, 1'b0, 16'd3, 16'd1, 16'd0, 16'd3);
        release_out("w0");

        // Unpopulated (type 10) with coordinates that would be in bounds as a sprite
        send(mk(2'b10, 16'd16, 16'd8, 16'd0, 16'd0, 16'd0), 11'd2, 11'd2);
        wait_valid(lat);
        chk("unpop_latency", lat, 32'd1);
        expect_res("unpop", 1'b0, 1'b0, 16'd2, 16'd2, 16'd0, 16'd2);
        release_out("unpop");

        // 5. Backpressure then back-to-back accept
        send(mk(2'b11, 16'd16, 16'd8, 16'd100, 16'd50, 16'd0), 11'd110, 11'd55);
        wait_valid(lat);
        chk("t5_latency", lat, 32'd1);
        held_x = 16'd10;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("t5_hold_out_valid", {31'd0, out_valid}, 32'd1);
            chk("t5_hold_in_ready",  {31'd0, in_ready},  32'd0);
            chk("t5_hold_layerX",    {16'd0, layerX},    {16'd0, held_x});
            chk("t5_hold_readRamEn", {31'd0, readRamEn}, 32'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        hdr = mk(2'b11, 16'd16, 16'd8, 16'd0, 16'd0, 16'd0);
        pixelX = 11'd3; pixelY = 11'd4;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("t5_idle_in_ready",  {31'd0, in_ready},  32'd1);
        chk("t5_idle_out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("t5_b2b_accepted", {31'd0, in_ready}, 32'd0);
        wait_valid(lat);
        chk("t5_b2b_latency", lat, 32'd1);
        expect_res("t5b", 1'b1, 1'b0, 16'd3, 16'd4, 16'd0, 16'd3);
        release_out("t5b");

        // 6. Reset in the middle of a divide
        send(mk(2'b01, 16'd8, 16'd12, 16'd0, 16'd0, 16'd5), 11'd37, 11'd3);
        repeat (5) @(posedge clk);
        #1;
        chk("t6_in_div_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        chk("t6_rst_in_ready",    {31'd0, in_ready},    32'd1);
        chk("t6_rst_out_valid",   {31'd0, out_valid},   32'd0);
        chk("t6_rst_readRamEn",   {31'd0, readRamEn},   32'd0);
        chk("t6_rst_readFlashEn", {31'd0, readFlashEn}, 32'd0);
        chk("t6_rst_layerX",      {16'd0, layerX},      32'd0);
        chk("t6_rst_layerY",      {16'd0, layerY},      32'd0);
        chk("t6_rst_charIndex",   {16'd0, charIndex},   32'd0);
        chk("t6_rst_charCol",     {16'd0, charCol},     32'd0);
        chk("t6_rst_fontIdx",     {16'd0, fontIdx},     32'd0);
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        chk("t6_aborted_never_valid", seen, 32'd0);
        chk("t6_idle_after", {31'd0, in_ready}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
